// File: rtl/uart_lb_pkg.sv
// -----------------------------------------------------------------------------
// uart_lb_pkg
// Shared definitions for the UART loopback checker:
//   - lbState_t    : checker FSM state encoding
//   - LFSR_SEED    : PRBS seed loaded at the start of every run
//   - LFSR_TAPS    : tap mask for x^8+x^6+x^5+x^4+1 (Fibonacci, shift left)
//   - clksPerBit() : clock cycles per serial bit for a given clock/baud pair
//   - lfsrNext()   : one step of the PRBS generator
// -----------------------------------------------------------------------------
package uart_lb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_BYTE,
        WAIT_RX,
        RX_BYTE,
        CHECK,
        DONE
    } lbState_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Register bits 7,5,4,3 correspond to polynomial terms x^8, x^6, x^5, x^4.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int clksPerBit(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

    function automatic logic [7:0] lfsrNext(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/uart_lb_baud.sv
// -----------------------------------------------------------------------------
// uart_lb_baud
// Reloadable bit-period down-counter. After a reload the counter holds
// CLKS_PER_BIT-1 and counts down while enabled, wrapping back to the full
// period on its own, so consecutive bits need no further reloads.
//
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-low reset
//   reload   in  restart the bit period (takes priority over enable)
//   enable   in  count this cycle
//   midTick  out one-cycle pulse CLKS_PER_BIT/2 cycles into each bit
//   endTick  out one-cycle pulse on the last cycle of each bit
// -----------------------------------------------------------------------------
module uart_lb_baud #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic enable,
    output logic midTick,
    output logic endTick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT - 1 - CLKS_PER_BIT / 2);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= FULL;
        end else if (enable) begin
            cnt <= (cnt == '0) ? FULL : cnt - CNT_W'(1);
        end
    end

    assign midTick = enable && !reload && (cnt == MID);
    assign endTick = enable && !reload && (cnt == '0);

endmodule

// File: rtl/uart_lb_checker.sv
// -----------------------------------------------------------------------------
// uart_lb_checker
// Drives NUM_BYTES 8N1 bytes toward a loopback responder and checks that each
// echo equals the sent payload + 1 (mod 256). Missing echoes (timeout),
// framing errors and mismatches each count one error per byte, saturating
// at 255. The run result is held on o_pass / o_fail until the next start.
//
// Build option:
//   UART_LB_PRBS_EN  payload from an 8-bit PRBS (seed 0x01, one step per
//                    byte) instead of the byte index.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   i_start     in   one-cycle pulse; honoured only in IDLE and DONE
//   serialTX    out  8N1 stream to the responder (idle high)
//   serialRX    in   asynchronous 8N1 echo from the responder
//   o_busy      out  run in progress
//   o_pass      out  last run finished with zero errors
//   o_fail      out  last run finished with one or more errors
//   o_errCount  out  errors in the current / last run
//   o_lastRx    out  most recently received echo byte
// -----------------------------------------------------------------------------
module uart_lb_checker
    import uart_lb_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int NUM_BYTES    = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       serialTX,
    input  logic       serialRX,
    output logic       o_busy,
    output logic       o_pass,
    output logic       o_fail,
    output logic [7:0] o_errCount,
    output logic [7:0] o_lastRx
);

    localparam int CLKS_PER_BIT   = clksPerBit(CLK_FREQ, BAUD);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      LAST_IDX = 8'(NUM_BYTES - 1);

    lbState_t state, nextState;

    // Receive synchronizer and edge detector
    logic rxSync1, rxSync2, rxPrev, rxFall;

    // Bit timing
    logic txMid, txEnd, rxMid, rxEnd;
    logic unusedTicks;

    // Datapath
    logic [9:0]      txShift;
    logic [3:0]      txBitCnt;
    logic [3:0]      rxBitCnt;
    logic [7:0]      rxShift;
    logic            frameErr;
    logic            timedOut;
    logic [TO_W-1:0] toCnt;
    logic [7:0]      byteIdx;
    logic [7:0]      payload;
    logic [7:0]      txData;
    logic [7:0]      errCount;
    logic [7:0]      errNext;
    logic            byteErr;
    logic            passReg, failReg;
    logic [7:0]      lastRx;

    // FSM strobes
    logic startRun, loadTx, rxStart, toExpire;

    assign rxFall = rxPrev && !rxSync2;

    // ---------------------------------------------------------------- payload
`ifdef UART_LB_PRBS_EN
    logic [7:0] lfsr;
    assign payload = lfsr;
    assign txData  = startRun ? LFSR_SEED : lfsrNext(lfsr);
`else
    assign payload = byteIdx;
    assign txData  = startRun ? 8'h00 : byteIdx + 8'd1;
`endif

    // ------------------------------------------------------------ bit timing
    uart_lb_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) txBaud (
        .clk     (clk),
        .rst     (rst),
        .reload  (loadTx),
        .enable  (state == TX_BYTE),
        .midTick (txMid),
        .endTick (txEnd)
    );

    uart_lb_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxBaud (
        .clk     (clk),
        .rst     (rst),
        .reload  (rxStart),
        .enable  (state == RX_BYTE),
        .midTick (rxMid),
        .endTick (rxEnd)
    );

    // TX only needs end-of-bit, RX only needs mid-bit.
    assign unusedTicks = txMid | rxEnd;

    // -------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------ next-state logic
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        nextState = state;
        startRun  = 1'b0;
        loadTx    = 1'b0;
        rxStart   = 1'b0;
        toExpire  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    startRun  = 1'b1;
                    loadTx    = 1'b1;
                    nextState = TX_BYTE;
                end
            end
            TX_BYTE: begin
                if (txEnd && txBitCnt == 4'd9) begin
                    nextState = WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (rxFall) begin
                    rxStart   = 1'b1;
                    nextState = RX_BYTE;
                end else if (toCnt == TO_LAST) begin
                    toExpire  = 1'b1;
                    nextState = CHECK;
                end
            end
            RX_BYTE: begin
                if (rxMid) begin
                    // A start bit that is high again at its centre was noise.
                    if (rxBitCnt == 4'd0 && rxSync2) begin
                        nextState = WAIT_RX;
                    end else if (rxBitCnt == 4'd9) begin
                        nextState = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byteIdx == LAST_IDX) begin
                    nextState = DONE;
                end else begin
                    loadTx    = 1'b1;
                    nextState = TX_BYTE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // ---------------------------------------------------------- error count
    // A timeout, a framing error and a data mismatch on one byte count once.
    assign byteErr = timedOut || frameErr || (rxShift != payload + 8'd1);

    always_comb begin
        errNext = errCount;
        if (state == CHECK && byteErr && errCount != 8'hFF) begin
            errNext = errCount + 8'd1;
        end
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxSync1  <= 1'b1;
            rxSync2  <= 1'b1;
            rxPrev   <= 1'b1;
            txShift  <= '1;
            txBitCnt <= '0;
            rxBitCnt <= '0;
            rxShift  <= '0;
            frameErr <= 1'b0;
            timedOut <= 1'b0;
            toCnt    <= '0;
            byteIdx  <= '0;
            errCount <= '0;
            passReg  <= 1'b0;
            failReg  <= 1'b0;
            lastRx   <= '0;
`ifdef UART_LB_PRBS_EN
            lfsr     <= LFSR_SEED;
`endif
        end else begin
            rxSync1 <= serialRX;
            rxSync2 <= rxSync1;
            rxPrev  <= rxSync2;

            // Transmit shifter: {stop, data[7:0], start}, LSB on the line.
            if (loadTx) begin
                txShift  <= {1'b1, txData, 1'b0};
                txBitCnt <= '0;
                timedOut <= 1'b0;
                frameErr <= 1'b0;
            end else if (state == TX_BYTE && txEnd) begin
                txShift  <= {1'b1, txShift[9:1]};
                txBitCnt <= txBitCnt + 4'd1;
            end

            // The echo timeout only advances in WAIT_RX, so a false start
            // resumes where it left off instead of restarting the window.
            if (state == TX_BYTE) begin
                toCnt <= '0;
            end else if (state == WAIT_RX && !rxFall) begin
                toCnt <= toCnt + TO_W'(1);
            end
            if (toExpire) begin
                timedOut <= 1'b1;
            end

            // Receive: bit 0 is the start bit, 1..8 data, 9 stop.
            if (rxStart) begin
                rxBitCnt <= '0;
            end else if (state == RX_BYTE && rxMid) begin
                rxBitCnt <= rxBitCnt + 4'd1;
                if (rxBitCnt >= 4'd1 && rxBitCnt <= 4'd8) begin
                    rxShift <= {rxSync2, rxShift[7:1]};
                end
                if (rxBitCnt == 4'd9) begin
                    frameErr <= !rxSync2;
                end
            end

            if (state == CHECK) begin
                errCount <= errNext;
                if (!timedOut) begin
                    lastRx <= rxShift;
                end
                if (byteIdx == LAST_IDX) begin
                    passReg <= (errNext == 8'd0);
                    failReg <= (errNext != 8'd0);
                end else begin
                    byteIdx <= byteIdx + 8'd1;
`ifdef UART_LB_PRBS_EN
                    lfsr    <= lfsrNext(lfsr);
`endif
                end
            end

            if (startRun) begin
                errCount <= '0;
                passReg  <= 1'b0;
                failReg  <= 1'b0;
                byteIdx  <= '0;
`ifdef UART_LB_PRBS_EN
                lfsr     <= LFSR_SEED;
`endif
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign serialTX   = (state == TX_BYTE) ? txShift[0] : 1'b1;
    assign o_busy     = (state == TX_BYTE) || (state == WAIT_RX) ||
                        (state == RX_BYTE) || (state == CHECK);
    assign o_pass     = passReg;
    assign o_fail     = failReg;
    assign o_errCount = errCount;
    assign o_lastRx   = lastRx;

endmodule

// File: tb/tb_uart_lb_checker.sv
// -----------------------------------------------------------------------------
// tb_uart_lb_checker
// Bench for uart_lb_checker at a reduced bit rate (32 clocks per bit).
// A decoder process captures every byte on serialTX; a responder process
// echoes each one according to a per-byte plan (correct, unchanged, corrupted,
// bad stop bit, no echo, optional noise glitch first). Expected results are
// derived from the plan alone.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_lb_checker;

    localparam int CLK_FREQ = 3200;
    localparam int BAUD     = 100;
    localparam int NB       = 4;
    localparam int TO_BITS  = 20;
    localparam int C        = CLK_FREQ / BAUD;
    localparam int T        = TO_BITS * C;

    typedef enum int {E_OK, E_SAME, E_WRONG, E_BADSTOP, E_NONE} echo_e;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       i_start  = 1'b0;
    logic       serialRX = 1'b1;
    logic       serialTX;
    logic       o_busy, o_pass, o_fail;
    logic [7:0] o_errCount, o_lastRx;

    int numChecks = 0;
    int numErrors = 0;
    int cyc       = 0;

    echo_e      planMode   [NB];
    int         planDelay  [NB];
    bit         planGlitch [NB];
    logic [7:0] planMask   [NB];

    logic [7:0] txSeen[$];
    logic [7:0] txQ[$];
    int         txStartCyc[$];
    int         echoIdx     = 0;
    logic [7:0] modelLastRx = 8'h00;

    uart_lb_checker #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .NUM_BYTES    (NB),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .serialTX   (serialTX),
        .serialRX   (serialRX),
        .o_busy     (o_busy),
        .o_pass     (o_pass),
        .o_fail     (o_fail),
        .o_errCount (o_errCount),
        .o_lastRx   (o_lastRx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        numChecks++;
        if (got != exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Payload of byte k: the index, or k steps of x^8+x^6+x^5+x^4+1 from 0x01.
    function automatic logic [7:0] expPayload(input int k);
`ifdef UART_LB_PRBS_EN
        logic [7:0] s;
        s = 8'h01;
        for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
`else
        return 8'(k);
`endif
    endfunction

    function automatic logic [7:0] echoValue(input int k);
        logic [7:0] p;
        p = expPayload(k);
        case (planMode[k])
            E_SAME:  return p;
            E_WRONG: return (p + 8'd1) ^ planMask[k];
            default: return p + 8'd1;
        endcase
    endfunction

    // ---------------------------------------------------- serialTX decoder
    initial begin : decoder
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !serialTX) begin
                txStartCyc.push_back(cyc);
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = serialTX;
                end
                repeat (C) @(negedge clk);
                txSeen.push_back(b);
                txQ.push_back(b);
            end
            prev = serialTX;
        end
    end

    // ----------------------------------------------------------- responder
    task automatic sendByte(input logic [7:0] v, input logic stopBit);
        serialRX = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serialRX = v[i];
            repeat (C) @(negedge clk);
        end
        serialRX = stopBit;
        repeat (C) @(negedge clk);
        serialRX = 1'b1;
    endtask

    initial begin : responder
        logic [7:0] b, v;
        int         k;
        forever begin
            while (txQ.size() == 0) @(negedge clk);
            b = txQ.pop_front();
            k = echoIdx;
            echoIdx++;
            if (k < NB && planMode[k] != E_NONE) begin
                repeat (C / 2 + planDelay[k]) @(negedge clk);
                if (planGlitch[k]) begin
                    serialRX = 1'b0;
                    repeat (10) @(negedge clk);
                    serialRX = 1'b1;
                    repeat (2 * C) @(negedge clk);
                end
                case (planMode[k])
                    E_SAME:    v = b;
                    E_WRONG:   v = (b + 8'd1) ^ planMask[k];
                    default:   v = b + 8'd1;
                endcase
                sendByte(v, (planMode[k] == E_BADSTOP) ? 1'b0 : 1'b1);
            end
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic setPlan(input echo_e m);
        for (int k = 0; k < NB; k++) begin
            planMode[k]   = m;
            planDelay[k]  = 6;
            planGlitch[k] = 1'b0;
            planMask[k]   = 8'h01;
        end
    endtask

    task automatic flush();
        txSeen.delete();
        txQ.delete();
        txStartCyc.delete();
        echoIdx = 0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic runAndCheck(input string name, input bit midPulse, input bit checkPeriod);
        int expErr, n;
        for (int k = 0; k < NB; k++) begin
            if (planMode[k] != E_OK) expErr++;
            if (planMode[k] != E_NONE) modelLastRx = echoValue(k);
        end
        flush();
        pulseStart();
        check({name, ".busy"}, o_busy, 1);
        check({name, ".errclr"}, o_errCount, 0);
        if (midPulse) begin
            repeat (3 * C) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            check({name, ".busyMid"}, o_busy, 1);
        end
        n = 0;
        while (o_busy && n < NB * (11 * C + T + 200)) begin
            @(negedge clk);
            n++;
        end
        check({name, ".done"}, o_busy, 0);
        check({name, ".pass"}, o_pass, (expErr == 0) ? 1 : 0);
        check({name, ".fail"}, o_fail, (expErr != 0) ? 1 : 0);
        check({name, ".errs"}, o_errCount, expErr);
        check({name, ".lastRx"}, o_lastRx, modelLastRx);
        check({name, ".nbytes"}, txSeen.size(), NB);
        for (int k = 0; k < NB && k < txSeen.size(); k++) begin
            check($sformatf("%s.tx%0d", name, k), txSeen[k], expPayload(k));
        end
        if (checkPeriod) begin
            check({name, ".toPeriod"},
                  (txStartCyc.size() >= 2) ? txStartCyc[1] - txStartCyc[0] : -1,
                  10 * C + T + 1);
        end
        repeat (2 * C) @(negedge clk);
        check({name, ".holdPass"}, o_pass, (expErr == 0) ? 1 : 0);
    endtask

    // -------------------------------------------------------------- main
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        setPlan(E_OK);
        repeat (3) @(negedge clk);
        #1;
        check("rst.tx",     serialTX,   1);
        check("rst.busy",   o_busy,     0);
        check("rst.pass",   o_pass,     0);
        check("rst.fail",   o_fail,     0);
        check("rst.errs",   o_errCount, 0);
        check("rst.lastRx", o_lastRx,   0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        setPlan(E_OK);   runAndCheck("plus1", 1'b0, 1'b0);
        setPlan(E_SAME); runAndCheck("same",  1'b0, 1'b0);
        setPlan(E_NONE); runAndCheck("none",  1'b0, 1'b1);

        setPlan(E_OK);
        planMode[1]   = E_BADSTOP;
        planGlitch[2] = 1'b1;
        runAndCheck("stopGlitch", 1'b0, 1'b0);

        setPlan(E_OK);   runAndCheck("midStart", 1'b1, 1'b0);

        // Reset in the middle of data bit 4 of byte 0.
        setPlan(E_NONE);
        flush();
        pulseStart();
        repeat (5 * C + C / 2) @(negedge clk);
        check("abort.txBit4", serialTX, expPayload(0) >> 4 & 1);
        rst = 1'b0;
        #1;
        check("abort.tx",     serialTX,   1);
        check("abort.busy",   o_busy,     0);
        check("abort.errs",   o_errCount, 0);
        check("abort.lastRx", o_lastRx,   0);
        modelLastRx = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        repeat (12 * C) @(negedge clk);
        setPlan(E_OK);   runAndCheck("afterRst", 1'b0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < NB; k++) begin
                int sel;
                sel = $urandom_range(0, 9);
                planMode[k]   = (sel <= 4) ? E_OK : (sel == 5) ? E_SAME :
                                (sel == 6) ? E_WRONG : (sel == 7) ? E_BADSTOP :
                                (sel == 8) ? E_NONE : E_OK;
                planDelay[k]  = $urandom_range(4, 100);
                planGlitch[k] = ($urandom_range(0, 3) == 0);
                planMask[k]   = 8'($urandom_range(1, 255));
            end
            runAndCheck($sformatf("rand%0d", r), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
